// File: rtl/bike_counter_dec_stop_ctrl.sv
// bike_counter_dec_stop_ctrl
// Loadable down-counter that saturates at MIN_VALUE. A controller loads a
// budget, such as remaining decoder iterations, and then spends it in
// variable-sized steps. Exhaustion is reported by a one-cycle done pulse and
// by the at_min level flag.
//
// Ports:
//   clk          rising-edge clock
//   resetn       synchronous active-low reset
//   load         load request, wins over enable
//   load_value   value to load; raised to MIN_VALUE if it is below it
//   enable       decrement request, honoured only while counting
//   step         unsigned decrement amount
//   cnt_out      registered counter value
//   busy         registered, high while counting (above MIN_VALUE)
//   at_min       registered, high while cnt_out == MIN_VALUE
//   done         one-cycle pulse when the counter reaches MIN_VALUE
//   load_clamped one-cycle pulse when a load was raised to MIN_VALUE
module bike_counter_dec_stop_ctrl #(
  parameter int SIZE       = 5,
  parameter int MIN_VALUE  = 0,
  parameter int STEP_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  load,
  input  logic [SIZE-1:0]       load_value,
  input  logic                  enable,
  input  logic [STEP_WIDTH-1:0] step,
  output logic [SIZE-1:0]       cnt_out,
  output logic                  busy,
  output logic                  at_min,
  output logic                  done,
  output logic                  load_clamped
);

  // One extra bit above the wider operand holds the borrow of the subtraction.
  localparam int DW = ((SIZE > STEP_WIDTH) ? SIZE : STEP_WIDTH) + 1;
  localparam logic [SIZE-1:0] MIN_S  = SIZE'(MIN_VALUE);
  localparam logic [DW-1:0]   MIN_DW = DW'(MIN_VALUE);

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    HOLD
  } stateT;

  stateT           state_q, state_d;
  logic [SIZE-1:0] cnt_q, cnt_d;
  logic            busy_q;
  logic            at_min_q;
  logic            done_q, done_d;
  logic            clamp_q, clamp_d;

  logic [SIZE:0]   loadDiff;
  logic            loadBelowMin;
  logic [SIZE-1:0] loadVal;
  logic [DW-1:0]   decDiff;
  logic            decSat;

  // The "below minimum" test uses the borrow of a subtraction rather than a
  // relational compare, so it stays a plain expression when MIN_VALUE is 0.
  assign loadDiff     = {1'b0, load_value} - {1'b0, MIN_S};
  assign loadBelowMin = loadDiff[SIZE];
  assign loadVal      = loadBelowMin ? MIN_S : load_value;

  // Both operands are zero-extended, so the top bit of the result is set
  // exactly when the step is larger than the current count.
  assign decDiff = DW'(cnt_q) - DW'(step);
  assign decSat  = decDiff[DW-1] | (decDiff <= MIN_DW);

  // Next-state logic: a load always wins, and enable only matters in COUNT.
  // Landing on MIN_VALUE by either path moves to HOLD and raises done.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    clamp_d = 1'b0;
    if (load) begin
      cnt_d   = loadVal;
      clamp_d = loadBelowMin;
      if (loadVal == MIN_S) begin
        state_d = HOLD;
        done_d  = 1'b1;
      end else begin
        state_d = COUNT;
      end
    end else if (enable && (state_q == COUNT)) begin
      if (decSat) begin
        cnt_d   = MIN_S;
        state_d = HOLD;
        done_d  = 1'b1;
      end else begin
        cnt_d = decDiff[SIZE-1:0];
      end
    end
  end

  // All state and outputs are registered here. The level flags are derived
  // from the next-state values so they line up with cnt_out in the same cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= MIN_S;
      busy_q   <= 1'b0;
      at_min_q <= 1'b1;
      done_q   <= 1'b0;
      clamp_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= (state_d == COUNT);
      at_min_q <= (cnt_d == MIN_S);
      done_q   <= done_d;
      clamp_q  <= clamp_d;
    end
  end

  assign cnt_out      = cnt_q;
  assign busy         = busy_q;
  assign at_min       = at_min_q;
  assign done         = done_q;
  assign load_clamped = clamp_q;

endmodule

// File: tb/tb_bike_counter_dec_stop_ctrl.sv
// tb_bike_counter_dec_stop_ctrl
// Directed bench for bike_counter_dec_stop_ctrl. Two instances share the
// stimulus: dut0 uses MIN_VALUE=0 and dut4 uses MIN_VALUE=4. Each step
// pushes the expected outputs of one instance into a scoreboard queue,
// and the entry is popped and compared one cycle later.
module tb_bike_counter_dec_stop_ctrl;

  logic       clk;
  logic       resetn;
  logic       load;
  logic [4:0] loadValue;
  logic       enable;
  logic [2:0] step;

  logic [4:0] cnt0, cnt4;
  logic       busy0, busy4;
  logic       atMin0, atMin4;
  logic       done0, done4;
  logic       clamp0, clamp4;

  typedef struct {
    logic       sel;
    logic [4:0] cnt;
    logic       busy;
    logic       atMin;
    logic       done;
    logic       clamp;
  } expT;

  expT scoreboard[$];

  int checks = 0;
  int passed = 0;

  bike_counter_dec_stop_ctrl #(.SIZE(5), .MIN_VALUE(0), .STEP_WIDTH(3)) dut0 (
    .clk          (clk),
    .resetn       (resetn),
    .load         (load),
    .load_value   (loadValue),
    .enable       (enable),
    .step         (step),
    .cnt_out      (cnt0),
    .busy         (busy0),
    .at_min       (atMin0),
    .done         (done0),
    .load_clamped (clamp0)
  );

  bike_counter_dec_stop_ctrl #(.SIZE(5), .MIN_VALUE(4), .STEP_WIDTH(3)) dut4 (
    .clk          (clk),
    .resetn       (resetn),
    .load         (load),
    .load_value   (loadValue),
    .enable       (enable),
    .step         (step),
    .cnt_out      (cnt4),
    .busy         (busy4),
    .at_min       (atMin4),
    .done         (done4),
    .load_clamped (clamp4)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: run still active at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Pops one scoreboard entry and compares every output of the selected instance.
  task automatic checkOutput();
    expT e;
    logic [4:0] oCnt;
    logic       oBusy, oAtMin, oDone, oClamp;
    checks++;
    assert (scoreboard.size() > 0) passed++;
    else $error("[TB] FAIL scoreboard: size %0d, required >0", scoreboard.size());
    if (scoreboard.size() > 0) begin
      e      = scoreboard.pop_front();
      oCnt   = e.sel ? cnt4   : cnt0;
      oBusy  = e.sel ? busy4  : busy0;
      oAtMin = e.sel ? atMin4 : atMin0;
      oDone  = e.sel ? done4  : done0;
      oClamp = e.sel ? clamp4 : clamp0;
      checks++;
      assert (oCnt === e.cnt) passed++;
      else $error("[TB] FAIL cnt_out(dut%0d) @%0t: got %0d, required %0d", e.sel ? 4 : 0, $time, oCnt, e.cnt);
      checks++;
      assert (oBusy === e.busy) passed++;
      else $error("[TB] FAIL busy(dut%0d) @%0t: got %b, required %b", e.sel ? 4 : 0, $time, oBusy, e.busy);
      checks++;
      assert (oAtMin === e.atMin) passed++;
      else $error("[TB] FAIL at_min(dut%0d) @%0t: got %b, required %b", e.sel ? 4 : 0, $time, oAtMin, e.atMin);
      checks++;
      assert (oDone === e.done) passed++;
      else $error("[TB] FAIL done(dut%0d) @%0t: got %b, required %b", e.sel ? 4 : 0, $time, oDone, e.done);
      checks++;
      assert (oClamp === e.clamp) passed++;
      else $error("[TB] FAIL load_clamped(dut%0d) @%0t: got %b, required %b", e.sel ? 4 : 0, $time, oClamp, e.clamp);
    end
  endtask

  // Drives one cycle of inputs, records what the selected instance must show
  // after the next edge, then checks it one time unit past that edge.
  task automatic applyStimulus(
    input logic       rn,
    input logic       ld,
    input logic [4:0] lv,
    input logic       en,
    input logic [2:0] st,
    input logic       sel,
    input logic [4:0] eCnt,
    input logic       eBusy,
    input logic       eAtMin,
    input logic       eDone,
    input logic       eClamp
  );
    expT e;
    resetn    = rn;
    load      = ld;
    loadValue = lv;
    enable    = en;
    step      = st;
    e.sel   = sel;
    e.cnt   = eCnt;
    e.busy  = eBusy;
    e.atMin = eAtMin;
    e.done  = eDone;
    e.clamp = eClamp;
    scoreboard.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  // Directed sequence covering the test plan, one instance at a time.
  initial begin
    resetn    = 1'b0;
    load      = 1'b0;
    loadValue = '0;
    enable    = 1'b0;
    step      = '0;

    // Reset state, then load 10 and count down by 1 with saturation at 0.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    applyStimulus(1, 1, 10, 0, 0, 0, 10, 1, 0, 0, 0);
    for (int i = 9; i >= 0; i--) begin
      applyStimulus(1, 0, 0, 1, 1, 0, 5'(i), (i != 0), (i == 0), (i == 0), 0);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0);
    end

    // Load 7, step 3: 7,4,1,0 with no wrap.
    applyStimulus(1, 1, 7, 0, 0, 0, 7, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 3, 0, 4, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 3, 0, 1, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 3, 0, 0, 0, 1, 1, 0);
    applyStimulus(1, 0, 0, 1, 3, 0, 0, 0, 1, 0, 0);

    // Loading exactly the minimum goes straight to HOLD with a done pulse.
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    applyStimulus(1, 0, 0, 1, 2, 0, 0, 0, 1, 0, 0);

    // Load 12, decrement to 8, then load and enable together: load wins.
    applyStimulus(1, 1, 12, 0, 0, 0, 12, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 4, 0, 8, 1, 0, 0, 0);
    applyStimulus(1, 1, 20, 1, 4, 0, 20, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 1, 0, 19, 1, 0, 0, 0);

    // Load 15, decrement twice, reset mid-count, then enable without reload.
    applyStimulus(1, 1, 15, 0, 0, 0, 15, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 1, 0, 14, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 1, 0, 13, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0);
    applyStimulus(1, 0, 0, 1, 3, 0, 0, 0, 1, 0, 0);

    // Enable with step 5 in IDLE, then step 0 while counting.
    applyStimulus(1, 0, 0, 1, 5, 0, 0, 0, 1, 0, 0);
    applyStimulus(1, 0, 0, 1, 5, 0, 0, 0, 1, 0, 0);
    applyStimulus(1, 1, 6, 0, 0, 0, 6, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 0, 0, 6, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 0, 0, 6, 1, 0, 0, 0);

    // MIN_VALUE=4 instance: clamped load, then 9,7,5,4.
    applyStimulus(0, 0, 0, 0, 0, 1, 4, 0, 1, 0, 0);
    applyStimulus(1, 1, 2, 0, 0, 1, 4, 0, 1, 1, 1);
    applyStimulus(1, 0, 0, 0, 0, 1, 4, 0, 1, 0, 0);
    applyStimulus(1, 1, 9, 0, 0, 1, 9, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 2, 1, 7, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 2, 1, 5, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 2, 1, 4, 0, 1, 1, 0);
    applyStimulus(1, 0, 0, 1, 2, 1, 4, 0, 1, 0, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/bike_counter_dec_stop_ctrl.md
Name: bike_counter_dec_stop_ctrl

Overview:
Loadable down-counter with saturation at MIN_VALUE and a load/done handshake. It is the counterpart of the team's incrementing stop-counter. Controllers load a budget, such as remaining decoder iterations or remaining sample positions, and decrement it by a variable step. The block reports exhaustion with a registered one-cycle done pulse and a level flag.

Parameters:
SIZE, 5, counter width in bits.
MIN_VALUE, 0, saturation floor; must satisfy 0 <= MIN_VALUE < 2**SIZE.
STEP_WIDTH, 3, width of the decrement step input.

Ports:
clk  input  1  clock, all logic on the rising edge.
resetn  input  1  reset, synchronous, active-low.
load  input  1  load request; takes priority over enable.
load_value  input  SIZE  value to load.
enable  input  1  decrement request; honoured only in state COUNT.
step  input  STEP_WIDTH  decrement amount, unsigned.
cnt_out  output  SIZE  registered counter value.
busy  output  1  high while in state COUNT.
at_min  output  1  registered; high when cnt_out == MIN_VALUE.
done  output  1  one-cycle pulse, high in the first cycle cnt_out reaches MIN_VALUE after a load or decrement.
load_clamped  output  1  one-cycle pulse; the last load had load_value < MIN_VALUE and was clamped.

Behaviour:
- Reset (resetn=0 at a clk edge), regardless of state or inputs:
  - cnt_out=MIN_VALUE, state IDLE, busy=0, at_min=1, done=0, load_clamped=0.
  - A reset mid-count discards the count. done is not pulsed.
- States:
  - IDLE: after reset, nothing loaded.
  - COUNT: cnt_out > MIN_VALUE, decrements accepted.
  - HOLD: cnt_out == MIN_VALUE, saturated.
- Load, in any state, with load=1:
  - Loaded value v = max(load_value, MIN_VALUE).
  - cnt_out <= v next cycle.
  - load_clamped <= (load_value < MIN_VALUE).
  - If v > MIN_VALUE: next state COUNT, done=0.
  - If v == MIN_VALUE: next state HOLD, done pulses next cycle.
  - load=1 together with enable=1: enable is ignored for that cycle.
  - Reloading in COUNT restarts the count. Reloading in HOLD re-arms the counter.
- Decrement, in COUNT with load=0 and enable=1:
  - Compute diff = {1'b0,cnt_out} - zero-extended step, at width max(SIZE,STEP_WIDTH)+1.
  - If diff is negative or diff <= MIN_VALUE: cnt_out <= MIN_VALUE, next state HOLD, done <= 1.
  - Otherwise cnt_out <= diff[SIZE-1:0] and the state stays COUNT.
  - step=0 leaves cnt_out unchanged and produces no done.
- Ignored inputs:
  - enable=0: cnt_out holds.
  - enable in IDLE or HOLD: ignored; cnt_out holds, done stays 0.
- Pulse outputs: done and load_clamped are high for exactly one cycle per event, never two consecutive cycles without a new event.
- Level outputs:
  - at_min is registered and tracks cnt_out every cycle.
  - busy = (state == COUNT), registered.
- Latency: every input takes effect on the cycle after the edge that samples it. There is no combinational path from inputs to outputs.
- No wrap-around is possible; cnt_out never drops below MIN_VALUE.

Test Plan:
1. Reset, then load=1 with load_value=10 (SIZE=5, MIN=0), then enable=1, step=1 held -> cnt_out 10,9,...,1,0; busy=1 until 0; done high only in the cycle cnt_out=0; cnt_out stays 0 for 3 further enabled cycles with no further done.
2. Load 7, step=3, enable held -> cnt_out 7,4,1,0 (saturates, no wrap to 30); done pulses once; at_min=1 from the cnt_out=0 cycle.
3. MIN_VALUE=4: load 2 -> cnt_out=4, load_clamped pulse, done pulse, state HOLD, busy=0; then load 9 with step=2 enabled -> 9,7,5,4 with done at 4.
4. Load 12, decrement to 8, then load=1 and enable=1 together with load_value=20 -> cnt_out=20, not 19; counting resumes from 20.
5. Load 15, decrement twice, then resetn=0 for one cycle -> cnt_out=MIN_VALUE, busy=0, done=0, at_min=1; with no reload, enable has no effect.
6. enable=1, step=5 in IDLE after reset -> cnt_out stays MIN_VALUE, no done; step=0 in COUNT holds the value with no done.
